iotdf_sched: RTL and testbench

IOTDF_SCHED -- requirements
Module: iotdf_sched

---
 rtl/iotdf_sched.sv | 127 ++++++++++++
 tb/tb_iotdf_sched.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iotdf_sched.sv
// Round-robin scheduler feeding two 128-bit requesters into an IOTDF byte port.
// Each grant covers a full round of WORDS_PER_ROUND words, followed by a drain gap.
//
// state | meaning
// IDLE  | arbitrate between req0/req1, latch owner and function select
// LOAD  | wait for owner word, capture it into the shift register, ack
// SEND  | stream 16 bytes MSB-first, stalling while busy
// DRAIN | hold off DRAIN_CYC cycles before the next arbitration
module iotdf_sched #(
  parameter int WORDS_PER_ROUND = 8,
  parameter int DRAIN_CYC       = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic [127:0] data0,
  input  logic [127:0] data1,
  input  logic [2:0]   fn0,
  input  logic [2:0]   fn1,
  output logic         ack0,
  output logic         ack1,
  input  logic         busy,
  output logic         in_en,
  output logic [7:0]   iot_in,
  output logic [2:0]   fn_sel,
  input  logic         dp_valid,
  input  logic [127:0] dp_out,
  output logic         res_valid,
  output logic [127:0] res_data,
  output logic         res_owner
);

  localparam int WCW = $clog2(WORDS_PER_ROUND) + 1;
  localparam int DCW = $clog2(DRAIN_CYC) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DRAIN} state_t;

  state_t         state;
  logic           owner;
  logic           prio;
  logic [127:0]   shift;
  logic [3:0]     byte_cnt;
  logic [WCW-1:0] word_cnt;
  logic [DCW-1:0] drain_cnt;

  logic           grant;
  logic           req_own;
  logic [127:0]   data_own;

  // prio names the requester that wins a tie; it flips to the other one at each grant
  always_comb begin
    grant    = (req0 & req1) ? prio : req1;
    req_own  = owner ? req1 : req0;
    data_own = owner ? data1 : data0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      prio      <= 1'b0;
      shift     <= '0;
      byte_cnt  <= '0;
      word_cnt  <= '0;
      drain_cnt <= '0;
      fn_sel    <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      in_en     <= 1'b0;
      iot_in    <= '0;
    end else begin
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      in_en  <= 1'b0;
      iot_in <= '0;
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            owner    <= grant;
            prio     <= ~grant;
            fn_sel   <= grant ? fn1 : fn0;
            word_cnt <= '0;
            byte_cnt <= '0;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (req_own) begin
            shift    <= data_own;
            byte_cnt <= '0;
            if (owner) ack1 <= 1'b1;
            else       ack0 <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (!busy) begin
            in_en    <= 1'b1;
            iot_in   <= shift[127:120];
            shift    <= {shift[119:0], 8'h00};
            byte_cnt <= byte_cnt + 4'd1;
            if (byte_cnt == 4'd15) begin
              word_cnt <= word_cnt + WCW'(1);
              if (word_cnt == WCW'(WORDS_PER_ROUND - 1)) begin
                drain_cnt <= '0;
                state     <= DRAIN;
              end else begin
                state <= LOAD;
              end
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == DCW'(DRAIN_CYC - 1)) state <= IDLE;
          else drain_cnt <= drain_cnt + DCW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign res_valid = dp_valid;
  assign res_data  = dp_out;
  assign res_owner = owner;

endmodule

// File: tb/tb_iotdf_sched.sv
// Scoreboard bench for iotdf_sched: requester models feed word queues, acks push
// the expected bytes, and every in_en byte is popped and compared.
module tb_iotdf_sched;
  logic         clk = 1'b0, rst = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0, busy = 1'b0, dp_valid = 1'b0;
  logic [127:0] data0 = '0, data1 = '0, dp_out = '0;
  logic [2:0]   fn0 = '0, fn1 = '0;
  logic         ack0, ack1, in_en, res_valid, res_owner;
  logic [7:0]   iot_in;
  logic [2:0]   fn_sel;
  logic [127:0] res_data;

  iotdf_sched #(.WORDS_PER_ROUND(8), .DRAIN_CYC(4)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .fn0(fn0), .fn1(fn1), .ack0(ack0), .ack1(ack1), .busy(busy), .in_en(in_en),
    .iot_in(iot_in), .fn_sel(fn_sel), .dp_valid(dp_valid), .dp_out(dp_out),
    .res_valid(res_valid), .res_data(res_data), .res_owner(res_owner)
  );

  always #5 clk = ~clk;

  int           n_cmp = 0, n_err = 0;
  logic [127:0] wq0[$], wq1[$];
  logic [7:0]   exp_bytes[$];
  logic         exp_ack_owner[$];
  int           gaps[$];
  int           zrun = 0;
  int           ack_cnt0 = 0, ack_cnt1 = 0, byte_total = 0;
  logic [2:0]   cur_fn = '0;
  logic         mon_k, mon_e;
  logic [127:0] mon_w;
  logic [7:0]   mon_b;

  // Scoreboard and requester model, evaluated mid-cycle
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (ack0 || ack1) begin
        mon_k = ack1;
        n_cmp++;
        if (ack0 && ack1) begin
          n_err++; $display("FAIL ack_both: ack0=%0b ack1=%0b, required one-hot", ack0, ack1);
        end else if (exp_ack_owner.size() == 0) begin
          n_err++; $display("FAIL ack_owner: got ack%0d, required no ack", mon_k);
        end else begin
          mon_e = exp_ack_owner.pop_front();
          if (mon_k !== mon_e) begin
            n_err++; $display("FAIL ack_owner: got ack%0d, required ack%0d", mon_k, mon_e);
          end
        end
        n_cmp++;
        if (res_owner !== mon_k) begin
          n_err++; $display("FAIL res_owner: got %0b, required %0b", res_owner, mon_k);
        end
        if (mon_k) ack_cnt1++; else ack_cnt0++;
        cur_fn = mon_k ? fn1 : fn0;
        if (mon_k ? (wq1.size() != 0) : (wq0.size() != 0)) begin
          mon_w = mon_k ? wq1.pop_front() : wq0.pop_front();
          for (int i = 0; i < 16; i++) exp_bytes.push_back(mon_w[127-8*i -: 8]);
        end
      end
      if (in_en) begin
        byte_total++;
        n_cmp++;
        if (exp_bytes.size() == 0) begin
          n_err++; $display("FAIL byte: got in_en with %02h, required no byte", iot_in);
        end else begin
          mon_b = exp_bytes.pop_front();
          if (iot_in !== mon_b) begin
            n_err++; $display("FAIL byte: got %02h, required %02h", iot_in, mon_b);
          end
        end
        n_cmp++;
        if (fn_sel !== cur_fn) begin
          n_err++; $display("FAIL fn_sel: got %0d, required %0d", fn_sel, cur_fn);
        end
        if (zrun > 0) gaps.push_back(zrun);
        zrun = 0;
      end else begin
        zrun++;
      end
    end
    req0  = (wq0.size() != 0);
    data0 = req0 ? wq0[0] : '0;
    req1  = (wq1.size() != 0);
    data1 = req1 ? wq1[0] : '0;
  end

  task automatic push_words(input logic k, input int n);
    for (int i = 0; i < n; i++) begin
      if (k) wq1.push_back({$urandom, $urandom, $urandom, $urandom});
      else   wq0.push_back({$urandom, $urandom, $urandom, $urandom});
    end
  endtask

  task automatic push_owner(input logic k, input int n);
    for (int i = 0; i < n; i++) exp_ack_owner.push_back(k);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (wq0.size() == 0 && wq1.size() == 0 && exp_bytes.size() == 0 &&
          exp_ack_owner.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (10) @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({in_en, iot_in, fn_sel, ack0, ack1, res_owner} !== 15'd0) begin
      n_err++;
      $display("FAIL reset: in_en=%0b iot_in=%02h fn_sel=%0d ack=%0b%0b owner=%0b, required all 0",
               in_en, iot_in, fn_sel, ack0, ack1, res_owner);
    end
    #1 rst = 1'b0;
  endtask

  task automatic test_single_round;
    int a0, b;
    bit ok;
    a0 = ack_cnt0; b = byte_total;
    fn0 = 3'd1;
    push_owner(1'b0, 8);
    push_words(1'b0, 8);
    wait_done(2000, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL single_timeout: round incomplete, required done"); end
    n_cmp++;
    if (ack_cnt0 - a0 != 8) begin
      n_err++; $display("FAIL single_acks: got %0d, required 8", ack_cnt0 - a0);
    end
    n_cmp++;
    if (byte_total - b != 128) begin
      n_err++; $display("FAIL single_bytes: got %0d, required 128", byte_total - b);
    end
    n_cmp++;
    if (fn_sel !== 3'd1) begin
      n_err++; $display("FAIL single_fn_hold: got %0d, required 1", fn_sel);
    end
  endtask

  task automatic test_alternate;
    bit ok;
    int exp_gap;
    @(negedge clk); #1 rst = 1'b1;
    @(negedge clk); #1 rst = 1'b0;
    fn0 = 3'd2; fn1 = 3'd5;
    gaps.delete(); zrun = 0;
    push_owner(1'b0, 8); push_owner(1'b1, 8); push_owner(1'b0, 8); push_owner(1'b1, 8);
    push_words(1'b0, 16);
    push_words(1'b1, 16);
    wait_done(4000, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL alt_timeout: rounds incomplete, required done"); end
    n_cmp++;
    if (gaps.size() != 32) begin
      n_err++; $display("FAIL alt_gap_count: got %0d, required 32", gaps.size());
    end else begin
      // one idle cycle between words, drain + grant + load between rounds
      for (int w = 1; w < 32; w++) begin
        exp_gap = (w % 8 == 0) ? 6 : 1;
        n_cmp++;
        if (gaps[w] != exp_gap) begin
          n_err++; $display("FAIL alt_gap: word %0d got %0d, required %0d", w, gaps[w], exp_gap);
        end
      end
    end
  endtask

  task automatic test_busy;
    int b, i;
    bit ok;
    b = byte_total;
    fn0 = 3'd3;
    push_owner(1'b0, 8);
    push_words(1'b0, 8);
    for (i = 0; i < 200 && byte_total < b + 4; i++) begin @(negedge clk); #1; end
    n_cmp++;
    if (byte_total != b + 4) begin
      n_err++; $display("FAIL busy_sync: got %0d bytes, required 4", byte_total - b);
    end
    busy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (in_en !== 1'b0) begin
        n_err++; $display("FAIL busy_stall: cycle %0d in_en=%0b, required 0", c, in_en);
      end
    end
    busy = 1'b0;
    wait_done(2000, ok);
    n_cmp++;
    if (!ok || byte_total - b != 128) begin
      n_err++; $display("FAIL busy_bytes: got %0d, required 128", byte_total - b);
    end
  endtask

  task automatic test_drop;
    int a0, a1, b, i;
    bit ok;
    a0 = ack_cnt0; a1 = ack_cnt1; b = byte_total;
    fn0 = 3'd4; fn1 = 3'd6;
    push_owner(1'b0, 8); push_owner(1'b1, 8);
    push_words(1'b0, 3);
    for (i = 0; i < 50 && ack_cnt0 == a0; i++) begin @(negedge clk); #1; end
    push_words(1'b1, 8);
    for (i = 0; i < 500 && byte_total < b + 48; i++) begin @(negedge clk); #1; end
    repeat (30) @(negedge clk);
    #1;
    n_cmp++;
    if (ack_cnt1 != a1 || byte_total != b + 48 || in_en !== 1'b0) begin
      n_err++;
      $display("FAIL drop_stall: ack1=%0d bytes=%0d in_en=%0b, required 0/48/0",
               ack_cnt1 - a1, byte_total - b, in_en);
    end
    push_words(1'b0, 5);
    wait_done(3000, ok);
    n_cmp++;
    if (!ok || ack_cnt0 - a0 != 8 || ack_cnt1 - a1 != 8) begin
      n_err++; $display("FAIL drop_resume: ack0=%0d ack1=%0d, required 8/8",
                        ack_cnt0 - a0, ack_cnt1 - a1);
    end
  endtask

  task automatic test_result;
    int a1, i;
    bit ok;
    a1 = ack_cnt1;
    fn1 = 3'd0;
    push_owner(1'b1, 8);
    push_words(1'b1, 8);
    for (i = 0; i < 50 && ack_cnt1 == a1; i++) begin @(negedge clk); #1; end
    dp_out = 128'h0123456789ABCDEF0123456789ABCDEF;
    dp_valid = 1'b1;
    #1;
    n_cmp++;
    if (res_valid !== 1'b1 || res_data !== 128'h0123456789ABCDEF0123456789ABCDEF ||
        res_owner !== 1'b1) begin
      n_err++; $display("FAIL result: valid=%0b data=%032h owner=%0b, required 1/0123..EF/1",
                        res_valid, res_data, res_owner);
    end
    @(negedge clk); #1 dp_valid = 1'b0;
    #1;
    n_cmp++;
    if (res_valid !== 1'b0) begin
      n_err++; $display("FAIL result_drop: valid=%0b, required 0", res_valid);
    end
    wait_done(2000, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL result_timeout: round incomplete, required done"); end
  endtask

  task automatic test_rst_mid;
    int a0, b, i;
    bit ok;
    b = byte_total;
    fn0 = 3'd7;
    push_owner(1'b0, 8);
    push_words(1'b0, 8);
    for (i = 0; i < 500 && byte_total < b + 53; i++) begin @(negedge clk); #1; end
    rst = 1'b1;
    wq0.delete(); exp_bytes.delete(); exp_ack_owner.delete();
    @(negedge clk);
    n_cmp++;
    if (in_en !== 1'b0 || fn_sel !== 3'd0 || ack0 !== 1'b0 || iot_in !== 8'd0) begin
      n_err++; $display("FAIL rst_mid: in_en=%0b fn_sel=%0d ack0=%0b iot_in=%02h, required 0",
                        in_en, fn_sel, ack0, iot_in);
    end
    #1 rst = 1'b0;
    a0 = ack_cnt0; b = byte_total;
    repeat (20) @(negedge clk);
    #1;
    n_cmp++;
    if (ack_cnt0 != a0 || byte_total != b) begin
      n_err++; $display("FAIL rst_quiet: acks=%0d bytes=%0d, required 0/0",
                        ack_cnt0 - a0, byte_total - b);
    end
    push_owner(1'b0, 8);
    push_words(1'b0, 8);
    wait_done(2000, ok);
    n_cmp++;
    if (!ok || ack_cnt0 - a0 != 8 || byte_total - b != 128) begin
      n_err++; $display("FAIL rst_restart: acks=%0d bytes=%0d, required 8/128",
                        ack_cnt0 - a0, byte_total - b);
    end
  endtask

  initial begin
    test_reset();
    test_single_round();
    test_alternate();
    test_busy();
    test_drop();
    test_result();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
